// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALU control codes and the
// requester identifier used by the round-robin picker.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 4;

    // ALU control codes understood by the downstream ALU
    localparam logic [OPW-1:0] ALU_ADD  = 4'b0011;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0010;
    localparam logic [OPW-1:0] ALU_SLL  = 4'b0001;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0110;
    localparam logic [OPW-1:0] ALU_SRL  = 4'b0111;
    localparam logic [OPW-1:0] ALU_OR   = 4'b1001;
    localparam logic [OPW-1:0] ALU_AND  = 4'b1010;
    localparam logic [OPW-1:0] ALU_IDLE = 4'b0000;

    // Identifies which requester was granted most recently
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   clk, reset : clock, synchronous active-high reset
//   elig[1:0]  : requester eligible this cycle
//   grant[1:0] : one-hot grant (all zero when nobody is eligible)
// The most recent winner is held internally; after reset requester 1 counts
// as the last winner so requester 0 wins the first contention.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    req_id_t last_q;
    req_id_t last_d;

    // Last-winner register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ1;
        end else begin
            last_q <= last_d;
        end
    end

    // Pick: on contention favour the requester that did not win last
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        unique case (elig)
            2'b01: begin
                grant  = 2'b01;
                last_d = REQ0;
            end
            2'b10: begin
                grant  = 2'b10;
                last_d = REQ1;
            end
            2'b11: begin
                if (last_q == REQ1) begin
                    grant  = 2'b01;
                    last_d = REQ0;
                end else begin
                    grant  = 2'b10;
                    last_d = REQ1;
                end
            end
            default: begin
                grant  = 2'b00;
                last_d = last_q;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. Each cycle at most one
// request is granted (round-robin), its operands are driven onto the ALU and
// the ALU result is captured into that requester's response register, which
// is held until the requester consumes it with a valid/ready handshake.
//   clk, reset                    : clock, synchronous active-high reset
//   reqN_valid/a/b/op, reqN_ready : request channel N (ready = granted now)
//   rspN_valid/result/zero, rspN_ready : response channel N
//   alu_a, alu_b, alu_control     : drive to the external ALU
//   alu_result                    : result from the external ALU
module alu_arbiter
    import alu_pkg::ALU_IDLE;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,

    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             rsp0_ready,

    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    input  logic             rsp1_ready,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    logic [1:0] slot_free;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       result_zero;

    // A slot can take a new result if empty or being drained this cycle
    assign slot_free[0] = !rsp0_valid || rsp0_ready;
    assign slot_free[1] = !rsp1_valid || rsp1_ready;

    // Nothing is accepted while reset is asserted
    assign elig[0] = req0_valid && slot_free[0] && !reset;
    assign elig[1] = req1_valid && slot_free[1] && !reset;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .elig  (elig),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Operand mux onto the shared ALU; idle drives all zeros
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = OPW'(ALU_IDLE);
        if (grant[0]) begin
            alu_a       = req0_a;
            alu_b       = req0_b;
            alu_control = req0_op;
        end else if (grant[1]) begin
            alu_a       = req1_a;
            alu_b       = req1_b;
            alu_control = req1_op;
        end
    end

    assign result_zero = (alu_result == '0);

    // Response slot 0: capture on grant, otherwise clear valid on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
        end else if (grant[0]) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= result_zero;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    // Response slot 1: capture on grant, otherwise clear valid on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else if (grant[1]) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= result_zero;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

endmodule
